eth_rx_frame_buffer: RTL
========================

ETH_RX_FRAME_BUFFER -- requirements
Module: eth_rx_frame_buffer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DEPTH, 512, data RAM depth in 32-bit words, power of 2, >=16.
REQ-002 LEN_DEPTH, 32, length-FIFO entries (max committed frames held), power of 2.
REQ-003 Ports SHALL be (name, direction, width, meaning): clk_250mhz, in, 1, sole clock; all logic is in this domain.
REQ-004 rst, in, 1, asynchronous active-high reset.
REQ-005 link_up, in, 1, aggregated link state from the RX mux; low means flush.
REQ-006 rx_bus, in, EthernetRxBus, fields start, data_valid, bytes_valid[2:0] (1..4), data[31:0] (first byte in [31:24]), commit, drop.
REQ-007 out_valid, out, 1, out_data/out_bytes_valid/out_last/out_len are valid.
REQ-008 out_ready, in, 1, consumer accepts the current word.
REQ-009 out_data, out, 32; out_bytes_valid, out, 3; out_last, out, 1 (final word of frame); out_len, out, 16 (frame length in bytes, constant for the whole frame).
REQ-010 frames_accepted, out, 32, wrapping count of committed frames; frames_dropped, out, 32, wrapping count of discarded frames.

Function
REQ-011 Write side SHALL keep wr_ptr, commit_ptr, rd_ptr (log2(DEPTH)+1 bits, wrap-around); RAM entries hold {bytes_valid, data} (35 bits).
REQ-012 Write FSM states SHALL be IDLE and RECEIVING; start -> RECEIVING, wr_ptr <= commit_ptr, byte count and truncate flag cleared.
REQ-013 start while RECEIVING SHALL discard the partial frame (frames_dropped +1) and begin the new one.
REQ-014 data_valid in RECEIVING SHALL write one word at wr_ptr and add bytes_valid to a 16-bit byte count; data_valid in IDLE SHALL be ignored.
REQ-015 start and data_valid in the same cycle SHALL treat the word as the first word of the new frame.
REQ-016 Writing when wr_ptr - rd_ptr == DEPTH, or byte count would exceed 65535, SHALL not write and SHALL set the truncate flag.
REQ-017 commit SHALL (after any same-cycle data_valid word) accept the frame only if truncate flag clear, byte count > 0 and length FIFO not full: push byte count, commit_ptr <= wr_ptr, frames_accepted +1; otherwise wr_ptr <= commit_ptr, frames_dropped +1; state -> IDLE.
REQ-018 drop SHALL set wr_ptr <= commit_ptr, frames_dropped +1, state -> IDLE; commit and drop together SHALL be treated as drop.
REQ-019 commit or drop in IDLE SHALL have no effect.
REQ-020 Read FSM states SHALL be IDLE, FETCH, STREAM; IDLE with length FIFO non-empty -> FETCH (pop length, issue RAM read, 1-cycle RAM latency) -> STREAM with out_valid high.
REQ-021 out_valid SHALL assert no later than 4 cycles after the commit cycle when the read side is IDLE.
REQ-022 In STREAM, outputs SHALL hold stable while out_valid && !out_ready; each out_valid && out_ready SHALL advance rd_ptr by one word and present the next word the following cycle with no bubbles.
REQ-023 out_last SHALL assert exactly on the word where accumulated bytes reach out_len; acceptance of it -> IDLE, rd_ptr equals that frame's committed end.
REQ-024 link_up low SHALL, in the same cycle, zero all pointers, empty the length FIFO, force both FSMs to IDLE and deassert out_valid; an in-progress received frame counts as dropped; counters are not cleared.
REQ-025 While link_up low, rx_bus SHALL be ignored.

Reset
REQ-026 rst high SHALL asynchronously set all pointers and counters to 0, FSMs to IDLE, out_valid/out_last 0, out_data 0, out_bytes_valid 0, out_len 0; RAM contents need not be cleared.
REQ-027 First rx_bus start SHALL be honoured on the first clock edge after rst deasserts.

Verification
REQ-028 start, 16 words (last bytes_valid=2), commit, out_ready=1 -> out_len=62, 16 words in order, out_last on word 16 with out_bytes_valid=2, frames_accepted=1.
REQ-029 start, 4 words, drop; then a 2-word committed frame -> only the 2-word frame emitted, frames_dropped=1, frames_accepted=1.
REQ-030 DEPTH=16, out_ready=0: 20-word frame then commit -> no output, frames_dropped=1; subsequent 8-word frame committed and emitted intact.
REQ-031 out_ready toggled 1/0 every cycle across two back-to-back committed frames -> words held stable while stalled, no loss or duplication, out_last once per frame.
REQ-032 link_up deasserted mid-output of a committed frame with another in RECEIVING -> out_valid 0 next cycle, frames_dropped +1, after link_up returns a new frame is emitted with out_len correct.
REQ-033 rst asserted mid-STREAM -> all outputs 0 immediately without a clock edge, counters 0.

Source files
------------

// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward receive buffer: frames are written as they arrive, released
// to the consumer only once committed, and rolled back on drop/overflow/link loss.
package eth_rx_pkg;
  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
    logic        commit;
    logic        drop;
  } EthernetRxBus;
endpackage

module eth_rx_frame_buffer
  import eth_rx_pkg::*;
#(
  parameter int DEPTH     = 512,
  parameter int LEN_DEPTH = 32
) (
  input  logic         clk_250mhz,
  input  logic         rst,
  input  logic         link_up,
  input  EthernetRxBus rx_bus,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic [2:0]   out_bytes_valid,
  output logic         out_last,
  output logic [15:0]  out_len,
  output logic [31:0]  frames_accepted,
  output logic [31:0]  frames_dropped
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LAW = $clog2(LEN_DEPTH);
  localparam logic [AW:0]  DEPTH_P     = (AW+1)'(DEPTH);
  localparam logic [AW:0]  PTR_ONE     = (AW+1)'(1);
  localparam logic [LAW:0] LEN_DEPTH_P = (LAW+1)'(LEN_DEPTH);
  localparam logic [LAW:0] LPTR_ONE    = (LAW+1)'(1);

  typedef enum logic {W_IDLE, W_RECEIVING} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rd_state_t;

  wr_state_t   wr_state, wr_state_nxt;
  rd_state_t   rd_state, rd_state_nxt;

  logic [AW:0] wr_ptr, wr_ptr_nxt, commit_ptr, commit_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [AW:0] base_ptr;
  logic [15:0] byte_cnt, byte_cnt_nxt, base_cnt;
  logic        trunc, trunc_nxt, base_trunc;
  logic [16:0] sum;
  logic        in_frame, wr_en, len_push, acc_inc;
  logic [1:0]  drop_inc;

  logic [34:0] mem [DEPTH];
  logic [34:0] rd_word_p1;
  logic [15:0] lf_mem [LEN_DEPTH];
  logic [LAW:0] lf_wr, lf_rd;
  logic        len_full, len_empty, len_pop;

  logic [15:0] len_q, len_q_nxt, rd_bytes, rd_bytes_nxt;
  logic        accept, word_last;
  logic [2:0]  cur_bv;

  assign len_full  = (lf_wr - lf_rd) == LEN_DEPTH_P;
  assign len_empty = lf_wr == lf_rd;

  // Write side: a start rebases onto commit_ptr so a same-cycle word lands as word 0
  always_comb begin
    wr_state_nxt   = wr_state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    byte_cnt_nxt   = byte_cnt;
    trunc_nxt      = trunc;
    base_ptr       = wr_ptr;
    base_cnt       = byte_cnt;
    base_trunc     = trunc;
    sum            = '0;
    in_frame       = 1'b0;
    wr_en          = 1'b0;
    len_push       = 1'b0;
    acc_inc        = 1'b0;
    drop_inc       = 2'd0;
    if (!link_up) begin
      wr_state_nxt   = W_IDLE;
      wr_ptr_nxt     = '0;
      commit_ptr_nxt = '0;
      byte_cnt_nxt   = '0;
      trunc_nxt      = 1'b0;
      if (wr_state == W_RECEIVING) drop_inc = 2'd1;
    end else begin
      if (rx_bus.start) begin
        base_ptr     = commit_ptr;
        base_cnt     = '0;
        base_trunc   = 1'b0;
        wr_state_nxt = W_RECEIVING;
        if (wr_state == W_RECEIVING) drop_inc = 2'd1;
      end
      in_frame     = rx_bus.start || (wr_state == W_RECEIVING);
      wr_ptr_nxt   = base_ptr;
      byte_cnt_nxt = base_cnt;
      trunc_nxt    = base_trunc;
      sum          = {1'b0, base_cnt} + 17'(rx_bus.bytes_valid);
      if (in_frame && rx_bus.data_valid) begin
        // Once truncated the frame is doomed, so stop consuming buffer space
        if (base_trunc || ((base_ptr - rd_ptr) == DEPTH_P) || sum[16]) begin
          trunc_nxt = 1'b1;
        end else begin
          wr_en        = 1'b1;
          wr_ptr_nxt   = base_ptr + PTR_ONE;
          byte_cnt_nxt = sum[15:0];
        end
      end
      if (in_frame && rx_bus.drop) begin
        wr_ptr_nxt   = commit_ptr;
        drop_inc     = drop_inc + 2'd1;
        wr_state_nxt = W_IDLE;
      end else if (in_frame && rx_bus.commit) begin
        wr_state_nxt = W_IDLE;
        if (!trunc_nxt && (byte_cnt_nxt != '0) && !len_full) begin
          len_push       = 1'b1;
          commit_ptr_nxt = wr_ptr_nxt;
          acc_inc        = 1'b1;
        end else begin
          wr_ptr_nxt = commit_ptr;
          drop_inc   = drop_inc + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_250mhz or posedge rst) begin
    if (rst) begin
      wr_state        <= W_IDLE;
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      byte_cnt        <= '0;
      trunc           <= 1'b0;
      frames_accepted <= '0;
      frames_dropped  <= '0;
    end else begin
      wr_state        <= wr_state_nxt;
      wr_ptr          <= wr_ptr_nxt;
      commit_ptr      <= commit_ptr_nxt;
      byte_cnt        <= byte_cnt_nxt;
      trunc           <= trunc_nxt;
      frames_accepted <= frames_accepted + 32'(acc_inc);
      frames_dropped  <= frames_dropped + 32'(drop_inc);
    end
  end

  always_ff @(posedge clk_250mhz) begin
    if (wr_en) mem[base_ptr[AW-1:0]] <= {rx_bus.bytes_valid, rx_bus.data};
    if (len_push) lf_mem[lf_wr[LAW-1:0]] <= byte_cnt_nxt;
  end

  always_ff @(posedge clk_250mhz or posedge rst) begin
    if (rst) begin
      lf_wr <= '0;
      lf_rd <= '0;
    end else if (!link_up) begin
      lf_wr <= '0;
      lf_rd <= '0;
    end else begin
      if (len_push) lf_wr <= lf_wr + LPTR_ONE;
      if (len_pop)  lf_rd <= lf_rd + LPTR_ONE;
    end
  end

  // Read side: RAM is addressed with the next pointer so the registered word
  // tracks acceptance with no bubble, and re-reads the same word while stalled
  assign cur_bv    = rd_word_p1[34:32];
  assign out_valid = link_up && (rd_state == R_STREAM);
  assign accept    = out_valid && out_ready;
  assign word_last = ({1'b0, rd_bytes} + 17'(cur_bv)) >= {1'b0, len_q};

  always_comb begin
    rd_state_nxt = rd_state;
    rd_ptr_nxt   = rd_ptr;
    rd_bytes_nxt = rd_bytes;
    len_q_nxt    = len_q;
    len_pop      = 1'b0;
    if (!link_up) begin
      rd_state_nxt = R_IDLE;
      rd_ptr_nxt   = '0;
      rd_bytes_nxt = '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (!len_empty) begin
            len_pop      = 1'b1;
            len_q_nxt    = lf_mem[lf_rd[LAW-1:0]];
            rd_bytes_nxt = '0;
            rd_state_nxt = R_FETCH;
          end
        end
        R_FETCH: rd_state_nxt = R_STREAM;
        R_STREAM: begin
          if (accept) begin
            rd_ptr_nxt   = rd_ptr + PTR_ONE;
            rd_bytes_nxt = rd_bytes + 16'(cur_bv);
            if (word_last) rd_state_nxt = R_IDLE;
          end
        end
        default: rd_state_nxt = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_250mhz or posedge rst) begin
    if (rst) begin
      rd_state <= R_IDLE;
      rd_ptr   <= '0;
      rd_bytes <= '0;
      len_q    <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      rd_ptr   <= rd_ptr_nxt;
      rd_bytes <= rd_bytes_nxt;
      len_q    <= len_q_nxt;
    end
  end

  // Stage p1: RAM read register
  always_ff @(posedge clk_250mhz) begin
    rd_word_p1 <= mem[rd_ptr_nxt[AW-1:0]];
  end

  assign out_data        = out_valid ? rd_word_p1[31:0] : '0;
  assign out_bytes_valid = out_valid ? cur_bv : '0;
  assign out_last        = out_valid && word_last;
  assign out_len         = len_q;

endmodule
